// File: rtl/mult_result_buffer_pkg.sv
// Shared types and constants for the multiplier issue/collect buffer.
// Entry layout is sized by the package localparams; the top's parameters default to them.
package mult_result_buffer_pkg;

  localparam int PKG_W       = 16;
  localparam int PKG_TAG_W   = 4;
  localparam int PKG_DEPTH   = 8;
  localparam int PKG_LATENCY = 4;

  localparam int CNT_W  = $clog2(PKG_DEPTH + 1);
  localparam int PTR_W  = $clog2(PKG_DEPTH);
  localparam int PIPE_D = PKG_LATENCY + 1;

  typedef struct packed {
    logic [PKG_TAG_W-1:0] tag;
    logic [2*PKG_W-1:0]   product;
  } result_entry_t;

  // Wraps explicitly at last so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                               input logic [PTR_W-1:0] last);
    if (ptr == last) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Synchronous FIFO of result entries with occupancy count and a fall-through head.
// Storage is not reset; only pointers and count are, so the head is qualified by count.
module mult_result_fifo
  import mult_result_buffer_pkg::*;
#(
  parameter int DEPTH = PKG_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  result_entry_t        din,
  input  logic                 pop,
  output result_entry_t        head,
  output logic [CNT_W-1:0]     count
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  result_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr, LAST);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr, LAST);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mult_result_buffer.sv
// Issue/collect controller around a fixed-latency, non-stallable multiplier.
// Optional upstream stall counter: define MULT_RESULT_BUFFER_STALL_CNT_EN.
//
// Handshakes: a transfer happens on an edge where valid && ready are both high;
// valid never depends on ready, and op_ready depends only on registered state.
module mult_result_buffer
  import mult_result_buffer_pkg::*;
#(
  parameter int W       = PKG_W,
  parameter int LATENCY = PKG_LATENCY,
  parameter int DEPTH   = PKG_DEPTH,
  parameter int TAG_W   = PKG_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic [TAG_W-1:0] op_tag,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_product,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*W-1:0]   res_product,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      stall_cycles
);

  localparam int PD   = LATENCY + 1;
  localparam int IF_W = $clog2(PD + 1);

  logic             rst_q;
  logic [PD-1:0]    pipe_v;
  logic [TAG_W-1:0] pipe_tag [PD];
  logic [IF_W-1:0]  inflight;
  logic [15:0]      credits_used;
  logic             accept;
  logic             pop;
  result_entry_t    cap_entry;
  result_entry_t    head;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) rst_q <= rst;

  // Every op in flight already owns a FIFO slot, so captures can never overflow.
  assign credits_used = 16'(count) + 16'(inflight);
  assign op_ready     = !rst_q && (credits_used < 16'(DEPTH));
  assign accept       = op_valid && op_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      pipe_v <= '0;
      for (int i = 0; i < PD; i++) pipe_tag[i] <= '0;
    end else begin
      if (accept) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end
      pipe_v      <= {pipe_v[PD-2:0], accept};
      pipe_tag[0] <= op_tag;
      for (int i = 1; i < PD; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PD; i++) inflight = inflight + IF_W'(pipe_v[i]);
  end

  assign cap_entry.tag     = pipe_tag[PD-1];
  assign cap_entry.product = mul_product;
  assign pop               = res_valid && res_ready;

  mult_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_v[PD-1]),
    .din   (cap_entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign res_valid   = (count != '0);
  assign res_product = res_valid ? head.product : '0;
  assign res_tag     = res_valid ? head.tag : '0;

`ifdef MULT_RESULT_BUFFER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (op_valid && !op_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
